// File: rtl/ddr3_axi_req_arbiter.sv
// AXI AR/AW/W front end for the DDR3 controller: buffers requests, pairs AW with W and issues one
// registered command at a time. Define DDR3_ARB_READ_PRIO_EN for strict read priority (default: round-robin).
module ddr3_axi_req_arbiter #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       wvalid,
  output logic                       wready,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic                       cmd_we,
  output logic [ADDR_W-1:0]          cmd_addr,
  output logic [DATA_W-1:0]          cmd_wdata,
  output logic [$clog2(DEPTH):0]     wr_pending
);

  localparam int AP = $clog2(DEPTH);
  localparam int PW = AP + 1;

  // Handshakes: a beat transfers on the rising edge where valid && ready; cmd_* are held
  // stable while cmd_valid && !cmd_ready and a new command loads when !cmd_valid || cmd_ready.

  logic [ADDR_W-1:0] ar_mem [DEPTH];
  logic [ADDR_W-1:0] aw_mem [DEPTH];
  logic [DATA_W-1:0] w_mem  [DEPTH];

  logic [PW-1:0] ar_wr, ar_rd, aw_wr, aw_rd, w_wr, w_rd;
  logic [PW-1:0] ar_cnt, aw_cnt, w_cnt;
  logic          ar_full, aw_full, w_full;
  logic          ar_empty, aw_empty, w_empty;
  logic          ar_push, aw_push, w_push;

  logic          rd_req, wr_req, hazard, rd_ok, load;
  logic          issue_rd, issue_wr;
  logic [PW-1:0] hz_off, hz_idx;
  logic [ADDR_W-1:0] ar_head, aw_head;
  logic [DATA_W-1:0] w_head;

  assign ar_full  = (ar_wr[PW-1] != ar_rd[PW-1]) && (ar_wr[AP-1:0] == ar_rd[AP-1:0]);
  assign aw_full  = (aw_wr[PW-1] != aw_rd[PW-1]) && (aw_wr[AP-1:0] == aw_rd[AP-1:0]);
  assign w_full   = (w_wr[PW-1]  != w_rd[PW-1])  && (w_wr[AP-1:0]  == w_rd[AP-1:0]);
  assign ar_empty = (ar_wr == ar_rd);
  assign aw_empty = (aw_wr == aw_rd);
  assign w_empty  = (w_wr == w_rd);
  assign ar_cnt   = ar_wr - ar_rd;
  assign aw_cnt   = aw_wr - aw_rd;
  assign w_cnt    = w_wr - w_rd;

  assign arready = !areset && !ar_full;
  assign awready = !areset && !aw_full;
  assign wready  = !areset && !w_full;

  assign ar_push = arvalid && arready;
  assign aw_push = awvalid && awready;
  assign w_push  = wvalid && wready;

  assign ar_head = ar_mem[ar_rd[AP-1:0]];
  assign aw_head = aw_mem[aw_rd[AP-1:0]];
  assign w_head  = w_mem[w_rd[AP-1:0]];

  assign wr_pending = (aw_cnt < w_cnt) ? aw_cnt : w_cnt;

  assign rd_req = !ar_empty;
  assign wr_req = !aw_empty && !w_empty;
  assign load   = !cmd_valid || cmd_ready;

  // Compare the AR head against every occupied AW slot at 2-byte word granularity.
  always_comb begin
    hazard = 1'b0;
    hz_off = '0;
    hz_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hz_off = PW'(i);
      hz_idx = aw_rd + hz_off;
      if (rd_req && (hz_off < aw_cnt) &&
          (aw_mem[hz_idx[AP-1:0]][ADDR_W-1:1] == ar_head[ADDR_W-1:1]))
        hazard = 1'b1;
    end
  end

  // A hazarded read stalls even when its conflicting write still waits for W data.
  assign rd_ok = rd_req && !hazard;

`ifdef DDR3_ARB_READ_PRIO_EN
  always_comb begin
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    if (load) begin
      if (wr_req && (aw_full || w_full || !rd_ok))
        issue_wr = 1'b1;
      else if (rd_ok)
        issue_rd = 1'b1;
    end
  end
`else
  logic rr_last;  // 1 = last issued command was a write

  always_comb begin
    issue_rd = 1'b0;
    issue_wr = 1'b0;
    if (load) begin
      if (wr_req && rd_ok) begin
        issue_rd = rr_last;
        issue_wr = !rr_last;
      end else if (wr_req) begin
        issue_wr = 1'b1;
      end else if (rd_ok) begin
        issue_rd = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset)
      rr_last <= 1'b1;
    else if (issue_rd || issue_wr)
      rr_last <= issue_wr;
  end
`endif

  always_ff @(posedge aclk) begin
    if (ar_push) ar_mem[ar_wr[AP-1:0]] <= araddr;
    if (aw_push) aw_mem[aw_wr[AP-1:0]] <= awaddr;
    if (w_push)  w_mem[w_wr[AP-1:0]]   <= wdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ar_wr     <= '0;
      ar_rd     <= '0;
      aw_wr     <= '0;
      aw_rd     <= '0;
      w_wr      <= '0;
      w_rd      <= '0;
      cmd_valid <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else begin
      if (ar_push)  ar_wr <= ar_wr + PW'(1);
      if (aw_push)  aw_wr <= aw_wr + PW'(1);
      if (w_push)   w_wr  <= w_wr + PW'(1);
      if (issue_rd) ar_rd <= ar_rd + PW'(1);
      if (issue_wr) begin
        aw_rd <= aw_rd + PW'(1);
        w_rd  <= w_rd + PW'(1);
      end
      if (load) begin
        cmd_valid <= issue_rd || issue_wr;
        cmd_we    <= issue_wr;
        cmd_addr  <= issue_wr ? aw_head : (issue_rd ? ar_head : '0);
        cmd_wdata <= issue_wr ? w_head : '0;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_axi_req_arbiter.sv
// Bench for ddr3_axi_req_arbiter: directed scenarios plus random traffic checked every cycle
// against a queue-level reference model of the request front end.
module tb_ddr3_axi_req_arbiter;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int EW     = 1 + ADDR_W + DATA_W;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [ADDR_W-1:0] araddr = '0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [ADDR_W-1:0] awaddr = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic [DATA_W-1:0] wdata = '0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [$clog2(DEPTH):0] wr_pending;

  ddr3_axi_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .wr_pending(wr_pending)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  // Reference model: request queues plus the command presented to the controller.
  logic [ADDR_W-1:0] m_ar[$];
  logic [ADDR_W-1:0] m_aw[$];
  logic [DATA_W-1:0] m_w[$];
  logic              m_valid = 1'b0;
  logic              m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic              m_rr_wr = 1'b1;

  logic [EW-1:0] obs_q[$];
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit rd, wr, haz, rd_ok, take_rd, take_wr;
    bit ar_ok, aw_ok, w_ok;
    if (areset) begin
      m_ar.delete(); m_aw.delete(); m_w.delete();
      m_valid = 0; m_we = 0; m_addr = '0; m_data = '0; m_rr_wr = 1;
      return;
    end
    ar_ok = m_ar.size() < DEPTH;
    aw_ok = m_aw.size() < DEPTH;
    w_ok  = m_w.size() < DEPTH;
    if (!m_valid || cmd_ready) begin
      rd = m_ar.size() > 0;
      wr = (m_aw.size() > 0) && (m_w.size() > 0);
      haz = 0;
      if (rd) foreach (m_aw[i]) if (m_aw[i][ADDR_W-1:1] == m_ar[0][ADDR_W-1:1]) haz = 1;
      rd_ok = rd && !haz;
      take_rd = 0; take_wr = 0;
`ifdef DDR3_ARB_READ_PRIO_EN
      if (wr && (!aw_ok || !w_ok || !rd_ok)) take_wr = 1;
      else if (rd_ok) take_rd = 1;
`else
      if (wr && rd_ok) begin
        if (m_rr_wr) take_rd = 1; else take_wr = 1;
      end else if (wr) take_wr = 1;
      else if (rd_ok) take_rd = 1;
`endif
      if (take_wr) begin
        m_valid = 1; m_we = 1; m_addr = m_aw.pop_front(); m_data = m_w.pop_front(); m_rr_wr = 1;
      end else if (take_rd) begin
        m_valid = 1; m_we = 0; m_addr = m_ar.pop_front(); m_data = '0; m_rr_wr = 0;
      end else begin
        m_valid = 0; m_we = 0; m_addr = '0; m_data = '0;
      end
    end
    if (arvalid && ar_ok) m_ar.push_back(araddr);
    if (awvalid && aw_ok) m_aw.push_back(awaddr);
    if (wvalid && w_ok)   m_w.push_back(wdata);
  endtask

  // One clock: drive inputs just after a falling edge, compare, then advance the model.
  task automatic step(input logic rst, input logic arv, input logic [ADDR_W-1:0] ara,
                      input logic awv, input logic [ADDR_W-1:0] awa,
                      input logic wv, input logic [DATA_W-1:0] wd, input logic rdy);
    int pend;
    areset = rst; arvalid = arv; araddr = ara; awvalid = awv; awaddr = awa;
    wvalid = wv; wdata = wd; cmd_ready = rdy;
    #1;
    pend = (m_aw.size() < m_w.size()) ? m_aw.size() : m_w.size();
    check("arready", arready, !rst && (m_ar.size() < DEPTH));
    check("awready", awready, !rst && (m_aw.size() < DEPTH));
    check("wready", wready, !rst && (m_w.size() < DEPTH));
    check("cmd_valid", cmd_valid, m_valid);
    check("cmd_we", cmd_we, m_we);
    check("cmd_addr", cmd_addr, m_addr);
    check("cmd_wdata", cmd_wdata, m_data);
    check("wr_pending", wr_pending, pend);
    if (cmd_valid && cmd_ready) obs_q.push_back({cmd_we, cmd_addr, cmd_wdata});
    @(posedge aclk);
    model_update();
    @(negedge aclk);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(0, 0, '0, 0, '0, 0, '0, rdy);
  endtask

  task automatic do_reset();
    step(1, 0, '0, 0, '0, 0, '0, 0);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_obs(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, obs_q[i], exp_q[i]);
  endtask

  initial begin
    @(negedge aclk);

    // Reset held three cycles with arvalid asserted, then released.
    repeat (3) step(1, 1, 26'h0000003, 0, '0, 0, '0, 0);
    areset = 0; arvalid = 0;
    #1 check("arready_after_reset", arready, 1'b1);
    check("cmd_valid_after_reset", cmd_valid, 1'b0);
    idle(1, 1);
    obs_q.delete();

    // Single read.
    step(0, 1, 26'h0123456, 0, '0, 0, '0, 1);
    idle(6, 1);
    exp_q.push_back({1'b0, 26'h0123456, 16'h0000});
    compare_obs("single_read");

    // Split write: W three cycles ahead of AW.
    do_reset();
    step(0, 0, '0, 0, '0, 1, 16'hBEEF, 1);
    idle(2, 1);
    step(0, 0, '0, 1, 26'h0000010, 0, '0, 1);
    idle(6, 1);
    exp_q.push_back({1'b1, 26'h0000010, 16'hBEEF});
    compare_obs("split_write");

    // Three reads and three writes queued together.
    do_reset();
    for (int i = 1; i <= 3; i++)
      step(0, 1, 26'(32'h1000 * i), 1, 26'(32'h4000 * i), 1, 16'(16'hA000 + i), 0);
    idle(2, 0);
    idle(12, 1);
`ifdef DDR3_ARB_READ_PRIO_EN
    for (int i = 1; i <= 3; i++) exp_q.push_back({1'b0, 26'(32'h1000 * i), 16'h0000});
    for (int i = 1; i <= 3; i++) exp_q.push_back({1'b1, 26'(32'h4000 * i), 16'(16'hA000 + i)});
`else
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back({1'b0, 26'(32'h1000 * i), 16'h0000});
      exp_q.push_back({1'b1, 26'(32'h4000 * i), 16'(16'hA000 + i)});
    end
`endif
    compare_obs("arbitration_order");

    // Read to the same word as a queued write must wait.
    do_reset();
    step(0, 1, 26'h0000101, 1, 26'h0000100, 1, 16'h1234, 0);
    idle(1, 0);
    idle(6, 1);
    exp_q.push_back({1'b1, 26'h0000100, 16'h1234});
    exp_q.push_back({1'b0, 26'h0000101, 16'h0000});
    compare_obs("hazard_order");

    // Backpressure: five reads with the controller stalled.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 26'(32'h200 + 4 * i), 0, '0, 0, '0, 0);
    check("bp_arready_full", arready, 1'b0);
    check("bp_head_held", cmd_addr, 26'h0000200);
    step(0, 1, 26'h0000300, 0, '0, 0, '0, 0);
    idle(2, 0);
    idle(10, 1);
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 26'(32'h200 + 4 * i), 16'h0000});
    compare_obs("backpressure_drain");

    // Random traffic over a small address pool so hazards occur often.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 249) == 0,
           $urandom_range(0, 1), 26'($urandom_range(0, 15) * 2 + $urandom_range(0, 1)),
           $urandom_range(0, 1), 26'($urandom_range(0, 15) * 2 + $urandom_range(0, 1)),
           $urandom_range(0, 1), 16'($urandom_range(0, 65535)),
           $urandom_range(0, 3) != 0);
    end
    idle(16, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
